// File: rtl/gsc_pkg.sv
// Shared encodings and helpers for the mole-game flow controller.
package gsc_pkg;

    typedef enum logic [2:0] {
        StReady      = 3'd0,
        StPlaying    = 3'd1,
        StPaused     = 3'd2,
        StStageClear = 3'd3,
        StGameOver   = 3'd4,
        StGameClear  = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CmdHit     = 4'd1,
        CmdMiss    = 4'd2,
        CmdPause   = 4'd4,
        CmdResume  = 4'd5,
        CmdStart   = 4'd8,
        CmdNewGame = 4'd15
    } cmd_e;

    localparam int unsigned QuotaW = 7;

    // Hits required to clear a 1-based stage.
    function automatic logic [QuotaW-1:0] quota_for(input int unsigned stage_num,
                                                    input int unsigned base,
                                                    input int unsigned step);
        int unsigned q;
        q = base + (stage_num - 1) * step;
        return QuotaW'(q);
    endfunction

endpackage

// File: rtl/gsc_sec_prescaler.sv
// Divides the system clock down to a one-cycle tick per second of game time.
module gsc_sec_prescaler #(
    parameter int unsigned CLK_HZ = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CntW-1:0] Terminal = CntW'(CLK_HZ - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == Terminal);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow controller for the mole game: FSM plus stage/lives/score/timer state.
// Define GSC_COMBO_EN to enable the consecutive-HIT combo bonus.
module game_state_ctrl
    import gsc_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 1000000,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned MAX_LIVES  = 3,
    parameter int unsigned SCORE_W    = 10,
    parameter int unsigned TIMER_W    = 7,
    parameter int unsigned READY_SEC  = 4,
    parameter int unsigned PLAY_SEC   = 60,
    parameter int unsigned CLEAR_SEC  = 3,
    parameter int unsigned BASE_QUOTA = 30,
    parameter int unsigned QUOTA_STEP = 5
) (
    input  logic                              clk_1mhz,
    input  logic                              rst,
    input  logic                              cmd_valid,
    input  logic [3:0]                        cmd_code,
    output logic                              cmd_done,
    output logic                              cmd_err,
    output logic                              sec_tick,
    output logic [2:0]                        state,
    output logic [$clog2(NUM_STAGES+1)-1:0]   stage,
    output logic [$clog2(MAX_LIVES+1)-1:0]    lives,
    output logic [TIMER_W-1:0]                timer,
    output logic [QuotaW-1:0]                 quota_left,
    output logic [SCORE_W-1:0]                score,
    output logic [SCORE_W-1:0]                high_score,
    output logic                              hs_updated
);
    localparam int unsigned StageW = $clog2(NUM_STAGES + 1);
    localparam int unsigned LivesW = $clog2(MAX_LIVES + 1);
    localparam int unsigned SumW   = SCORE_W + 1;
    localparam logic [QuotaW-1:0] FirstQuota = quota_for(1, BASE_QUOTA, QUOTA_STEP);

    state_e               state_q, state_d;
    logic [StageW-1:0]    stage_q, stage_d;
    logic [LivesW-1:0]    lives_q, lives_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [QuotaW-1:0]    quota_q, quota_d;
    logic [SCORE_W-1:0]   score_q, score_d, score_hit;
    logic [SCORE_W-1:0]   hs_q, hs_d;
    logic                 hsu_q, hsu_d;
    logic                 done_q, err_q, err_d, tick_q, tick_d;
    logic                 tick, run_en, timer_load, expire, finish, valid_state;
    logic [1:0]           hit_inc;
    logic [SumW-1:0]      score_sum;
`ifdef GSC_COMBO_EN
    logic [2:0]           combo_q, combo_d;
`endif

    gsc_sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk    (clk_1mhz),
        .rst    (rst),
        .clear  (timer_load),
        .enable (run_en),
        .tick   (tick)
    );

    assign valid_state = state_q inside {StReady, StPlaying, StPaused,
                                         StStageClear, StGameOver, StGameClear};
    assign run_en      = state_q inside {StReady, StPlaying, StStageClear};
    assign expire      = tick && (timer_q == TIMER_W'(1));

`ifdef GSC_COMBO_EN
    assign hit_inc = (combo_q >= 3'd4) ? 2'd2 : 2'd1;
`else
    assign hit_inc = 2'd1;
`endif
    assign score_sum = {1'b0, score_q} + SumW'(hit_inc);
    assign score_hit = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        lives_d    = lives_q;
        timer_d    = timer_q;
        quota_d    = quota_q;
        score_d    = score_q;
        hs_d       = hs_q;
        hsu_d      = hsu_q;
        err_d      = 1'b0;
        timer_load = 1'b0;
        finish     = 1'b0;
        tick_d     = tick && (timer_q != '0);
`ifdef GSC_COMBO_EN
        combo_d    = combo_q;
`endif
        // A load in the same cycle overrides the plain decrement.
        if (tick_d) begin
            timer_d = timer_q - 1'b1;
        end

        if (!valid_state) begin
            state_d    = StReady;
            timer_d    = TIMER_W'(READY_SEC);
            timer_load = 1'b1;
            err_d      = cmd_valid;
        end else if (expire) begin
            err_d = cmd_valid;
            case (state_q)
                StReady: begin
                    state_d    = StPlaying;
                    timer_d    = TIMER_W'(PLAY_SEC);
                    timer_load = 1'b1;
                end
                StPlaying: begin
                    state_d = StGameOver;
                    finish  = 1'b1;
                end
                StStageClear: begin
                    state_d    = StReady;
                    stage_d    = stage_q + 1'b1;
                    timer_d    = TIMER_W'(READY_SEC);
                    quota_d    = quota_for(32'(stage_q) + 1, BASE_QUOTA, QUOTA_STEP);
                    timer_load = 1'b1;
`ifdef GSC_COMBO_EN
                    combo_d    = '0;
`endif
                end
                default: ;
            endcase
        end else if (cmd_valid) begin
            case (cmd_code)
                CmdHit: begin
                    if (state_q == StPlaying) begin
                        score_d = score_hit;
                        quota_d = (quota_q != '0) ? quota_q - 1'b1 : '0;
`ifdef GSC_COMBO_EN
                        combo_d = (combo_q != 3'd7) ? combo_q + 1'b1 : combo_q;
`endif
                        if (quota_d == '0) begin
                            if (stage_q == StageW'(NUM_STAGES)) begin
                                state_d = StGameClear;
                                finish  = 1'b1;
                            end else begin
                                state_d    = StStageClear;
                                timer_d    = TIMER_W'(CLEAR_SEC);
                                timer_load = 1'b1;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CmdMiss: begin
                    if (state_q == StPlaying) begin
                        lives_d = (lives_q != '0) ? lives_q - 1'b1 : '0;
`ifdef GSC_COMBO_EN
                        combo_d = '0;
`endif
                        if (lives_d == '0) begin
                            state_d = StGameOver;
                            finish  = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CmdPause: begin
                    if (state_q == StPlaying) begin
                        state_d = StPaused;
`ifdef GSC_COMBO_EN
                        combo_d = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CmdResume: begin
                    if (state_q == StPaused) state_d = StPlaying;
                    else err_d = 1'b1;
                end
                CmdStart: begin
                    if (state_q == StReady) begin
                        state_d    = StPlaying;
                        timer_d    = TIMER_W'(PLAY_SEC);
                        timer_load = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CmdNewGame: begin
                    state_d    = StReady;
                    stage_d    = StageW'(1);
                    lives_d    = LivesW'(MAX_LIVES);
                    timer_d    = TIMER_W'(READY_SEC);
                    quota_d    = FirstQuota;
                    score_d    = '0;
                    hsu_d      = 1'b0;
                    timer_load = 1'b1;
`ifdef GSC_COMBO_EN
                    combo_d    = '0;
`endif
                end
                default: err_d = 1'b1;
            endcase
        end

        if (finish) begin
            hsu_d = score_d > hs_q;
            if (score_d > hs_q) hs_d = score_d;
        end
    end

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            state_q <= StReady;
            stage_q <= StageW'(1);
            lives_q <= LivesW'(MAX_LIVES);
            timer_q <= TIMER_W'(READY_SEC);
            quota_q <= FirstQuota;
            score_q <= '0;
            hs_q    <= '0;
            hsu_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tick_q  <= 1'b0;
`ifdef GSC_COMBO_EN
            combo_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            lives_q <= lives_d;
            timer_q <= timer_d;
            quota_q <= quota_d;
            score_q <= score_d;
            hs_q    <= hs_d;
            hsu_q   <= hsu_d;
            done_q  <= cmd_valid;
            err_q   <= err_d;
            tick_q  <= tick_d;
`ifdef GSC_COMBO_EN
            combo_q <= combo_d;
`endif
        end
    end

    assign state      = state_q;
    assign stage      = stage_q;
    assign lives      = lives_q;
    assign timer      = timer_q;
    assign quota_left = quota_q;
    assign score      = score_q;
    assign high_score = hs_q;
    assign hs_updated = hsu_q;
    assign cmd_done   = done_q;
    assign cmd_err    = err_q;
    assign sec_tick   = tick_q;

endmodule
